// File: rtl/decred_chain_hub.sv
// SPI fan-out hub: routes each host frame to the local bank, one client, all clients or none,
// and merges synchronised, latched, masked client interrupts into one registered host IRQ.
module decred_chain_hub #(
  parameter int unsigned       NUM_CLIENTS = 4,
  parameter int unsigned       ADDR_W      = 7,
  parameter int unsigned       IRQ_SYNC    = 2,
  parameter logic [ADDR_W-1:0] BCAST_ADDR  = '1,
  localparam int unsigned      IDX_W       = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1
) (
  input  logic                   iCLK,
  input  logic                   EXT_RESET_N,
  input  logic                   SCSN_fromHost,
  input  logic                   SCLK_fromHost,
  input  logic                   MOSI_fromHost,
  output logic                   MISO_toHost,
  input  logic                   address_strobe,
  input  logic [ADDR_W-1:0]      currentSPIAddr,
  input  logic [ADDR_W-1:0]      setSPIAddr,
  input  logic                   miso_local,
  output logic                   write_enable,
  input  logic                   cfg_write,
  input  logic [IDX_W-1:0]       cfg_index,
  input  logic [ADDR_W-1:0]      cfg_base,
  input  logic [ADDR_W-1:0]      cfg_span,
  output logic [NUM_CLIENTS-1:0] SCSN_toClient,
  output logic [NUM_CLIENTS-1:0] SCLK_toClient,
  output logic [NUM_CLIENTS-1:0] MOSI_toClient,
  input  logic [NUM_CLIENTS-1:0] MISO_fromClient,
  input  logic [NUM_CLIENTS-1:0] IRQ_fromClient,
  input  logic                   irq_local,
  input  logic [NUM_CLIENTS-1:0] irq_mask,
  input  logic [NUM_CLIENTS-1:0] irq_clear,
  output logic [NUM_CLIENTS-1:0] irq_pending,
  output logic                   IRQ_toHost,
  output logic [2:0]             route_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HDR    = 3'd1,
    LOCAL  = 3'd2,
    FWD    = 3'd3,
    BCAST  = 3'd4,
    ORPHAN = 3'd5
  } state_e;

  state_e                                 state_q, state_d;
  logic [IDX_W-1:0]                       idx_q, idx_d;
  logic [NUM_CLIENTS-1:0]                 chan_en_q, chan_en_d;
  logic                                   we_q, we_d;
  logic [NUM_CLIENTS-1:0][ADDR_W-1:0]     base_q, base_d;
  logic [NUM_CLIENTS-1:0][ADDR_W-1:0]     span_q, span_d;
  logic [IRQ_SYNC-1:0][NUM_CLIENTS-1:0]   sync_q, sync_d;
  logic [NUM_CLIENTS-1:0]                 last_q, last_d;
  logic [NUM_CLIENTS-1:0]                 pend_q, pend_d;
  logic                                   irq_q, irq_d;
  logic                                   hit;
  logic [IDX_W-1:0]                       hit_idx;

  // Lowest-numbered enabled entry whose [base, base+span) holds the address; no wrap.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
      if (!hit && (span_q[i] != '0) &&
          ({1'b0, currentSPIAddr} >= {1'b0, base_q[i]}) &&
          ({1'b0, currentSPIAddr} < ({1'b0, base_q[i]} + {1'b0, span_q[i]}))) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (SCSN_fromHost) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: state_d = HDR;
        HDR: begin
          if (address_strobe) begin
            if (currentSPIAddr == setSPIAddr)      state_d = LOCAL;
            else if (currentSPIAddr == BCAST_ADDR) state_d = BCAST;
            else if (hit) begin
              state_d = FWD;
              idx_d   = hit_idx;
            end else                               state_d = ORPHAN;
          end
        end
        default: ;
      endcase
    end

    chan_en_d = '1;
    we_d      = 1'b0;
    case (state_d)
      LOCAL: begin
        chan_en_d = '0;
        we_d      = 1'b1;
      end
      FWD: begin
        for (int unsigned i = 0; i < NUM_CLIENTS; i++) chan_en_d[i] = (idx_d == IDX_W'(i));
      end
      BCAST:   we_d = 1'b1;
      ORPHAN:  chan_en_d = '0;
      default: ;
    endcase
  end

  always_comb begin
    case (state_q)
      FWD:     MISO_toHost = MISO_fromClient[idx_q];
      ORPHAN:  MISO_toHost = 1'b0;
      default: MISO_toHost = miso_local;
    endcase
  end

  always_comb begin
    base_d = base_q;
    span_d = span_q;
    if (cfg_write && (32'(cfg_index) < NUM_CLIENTS)) begin
      base_d[cfg_index] = cfg_base;
      span_d[cfg_index] = cfg_span;
    end
  end

  always_comb begin
    sync_d = {sync_q[IRQ_SYNC-2:0], IRQ_fromClient};
    last_d = sync_q[IRQ_SYNC-1];
    pend_d = (pend_q & ~irq_clear) | (sync_q[IRQ_SYNC-1] & ~last_q);
    irq_d  = (|(pend_q & irq_mask)) | irq_local;
  end

  always_ff @(posedge iCLK or negedge EXT_RESET_N) begin
    if (!EXT_RESET_N) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      chan_en_q <= '1;
      we_q      <= 1'b0;
      base_q    <= '0;
      span_q    <= '0;
      span_q[0] <= '1;
      sync_q    <= '0;
      last_q    <= '0;
      pend_q    <= '0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      chan_en_q <= chan_en_d;
      we_q      <= we_d;
      base_q    <= base_d;
      span_q    <= span_d;
      sync_q    <= sync_d;
      last_q    <= last_d;
      pend_q    <= pend_d;
      irq_q     <= irq_d;
    end
  end

  // Reset forces every client select inactive even though chan_en resets to all ones.
  assign SCSN_toClient = {NUM_CLIENTS{SCSN_fromHost | ~EXT_RESET_N}} | ~chan_en_q;
  assign SCLK_toClient = {NUM_CLIENTS{SCLK_fromHost}};
  assign MOSI_toClient = {NUM_CLIENTS{MOSI_fromHost}};
  assign write_enable  = we_q;
  assign irq_pending   = pend_q;
  assign IRQ_toHost    = irq_q;
  assign route_state   = state_q;

endmodule

// File: doc/decred_chain_hub.md
Name: decred_chain_hub

Overview:
Parametrised successor to the single-client SPI pass-through used on each hashing die. It runs on the SPI-side clock and fans the host SPI bus out to NUM_CLIENTS downstream dies. Each frame is routed by its decoded address to the local register bank, one client port, all ports (broadcast), or nowhere. Per-client interrupts are synchronised, latched, masked and merged into a single host IRQ.

Parameters:
NUM_CLIENTS, 4, number of downstream client ports (1..16)
ADDR_W, 7, SPI chip-address width
IRQ_SYNC, 2, synchroniser depth on IRQ_fromClient (>=2)
BCAST_ADDR, all-ones, address that selects local plus every client port

Ports:
iCLK  in  1  SPI-domain clock
EXT_RESET_N  in  1  asynchronous active-low reset
SCSN_fromHost  in  1  host chip select, active low
SCLK_fromHost  in  1  host SPI clock
MOSI_fromHost  in  1  host data in
MISO_toHost  out  1  data to host
address_strobe  in  1  one-cycle pulse: frame address decoded
currentSPIAddr  in  ADDR_W  decoded frame address
setSPIAddr  in  ADDR_W  this die's own address
miso_local  in  1  local register-bank MISO
write_enable  out  1  local bank write permitted
cfg_write  in  1  route-table write strobe
cfg_index  in  max(1,clog2(NUM_CLIENTS))  table entry
cfg_base  in  ADDR_W  first address routed to entry
cfg_span  in  ADDR_W  number of addresses; 0 disables entry
SCSN_toClient  out  NUM_CLIENTS  per-port chip select
SCLK_toClient  out  NUM_CLIENTS  per-port clock (unconditional copy)
MOSI_toClient  out  NUM_CLIENTS  per-port data (unconditional copy)
MISO_fromClient  in  NUM_CLIENTS  per-port return data
IRQ_fromClient  in  NUM_CLIENTS  asynchronous client IRQs
irq_local  in  1  local bank interrupt
irq_mask  in  NUM_CLIENTS  1 = pending bit may assert host IRQ
irq_clear  in  NUM_CLIENTS  one-cycle clear pulses
irq_pending  out  NUM_CLIENTS  latched client IRQ flags
IRQ_toHost  out  1  merged interrupt, registered
route_state  out  3  FSM state, for debug

Behaviour:
- Reset values (async assert, sync release): FSM=IDLE; chan_en all ones; write_enable=0; irq_pending=0; IRQ_toHost=0; sync flops 0. Route table: entry 0 base=0, span=2^ADDR_W-1; all other entries span=0. Entry 0 therefore reproduces the legacy daisy-chain behaviour.
- SCSN_toClient[i] = SCSN_fromHost | ~chan_en[i]. chan_en is registered. SCLK and MOSI are passed unchanged.
- FSM states and encoding: IDLE=0, HDR=1, LOCAL=2, FWD=3, BCAST=4, ORPHAN=5.
  - IDLE -> HDR on SCSN_fromHost low. Sampled, no sync, because the host holds SCSN stable for several iCLK cycles.
  - HDR: chan_en all ones (the header reaches every client); MISO_toHost=miso_local.
  - address_strobe in HDR, cycle t: decide route; chan_en and write_enable update at t+1.
    - Priority 1: addr==setSPIAddr -> LOCAL.
    - Priority 2: addr==BCAST_ADDR -> BCAST.
    - Priority 3: lowest i with span_i!=0 and base_i <= addr < base_i+span_i -> FWD, store i. Compare at ADDR_W+1 bits, no wrap.
    - Otherwise -> ORPHAN.
  - LOCAL: chan_en=0; write_enable=1; MISO=miso_local.
  - FWD: chan_en=onehot(i); write_enable=0; MISO=MISO_fromClient[i] (combinational mux on the registered index).
  - BCAST: chan_en all ones; write_enable=1; MISO=miso_local.
  - ORPHAN: chan_en=0; write_enable=0; MISO=0.
  - Any state -> IDLE when SCSN_fromHost is high. chan_en returns to all ones and write_enable to 0 on the next cycle.
- address_strobe outside HDR, including a second strobe in the same frame, is ignored.
- cfg_write updates the entry the next cycle, including mid-frame. An already-latched route is never re-evaluated. An out-of-range cfg_index is ignored.
- IRQ path:
  - IRQ_SYNC-stage synchroniser per client, then a rising-edge detect sets irq_pending[i].
  - irq_clear[i] clears the bit. If set and clear occur in the same cycle, set wins.
  - IRQ_toHost <= |(irq_pending & irq_mask) | irq_local. This is one register stage, so latency from the edge is IRQ_SYNC+2 cycles.
- Reset mid-frame: all client selects go high (inactive) immediately; the pending frame is dropped.

Test Plan:
- Reset, then a frame to addr 0x05 with setSPIAddr=0x01 (default table) -> FWD to port 0: SCSN_toClient=4'b1110 from strobe+1, MISO follows MISO_fromClient[0], write_enable=0.
- Program entry 2 base=0x10 span=4, entry 0 span=0; frames to 0x13 and 0x14 -> 0x13 selects port 2 only; 0x14 goes to ORPHAN: all SCSN_toClient high, MISO_toHost=0.
- Frame to setSPIAddr, and to 0x7F -> LOCAL: clients deselected, write_enable=1. BCAST: all selected, write_enable=1, MISO=miso_local.
- Overlapping entries 1 and 3 both covering 0x20 -> port 1 chosen. A second address_strobe with 0x01 in the same frame -> no change.
- IRQ_fromClient[3] rises with mask[3]=1 -> irq_pending[3]=1 and IRQ_toHost=1 after 4 cycles. irq_clear[3] coincident with a new edge -> bit stays 1.
- EXT_RESET_N low during FWD -> SCSN_toClient all 1 in the same cycle; route_state=0; irq_pending=0.
